// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline state encodings, opcode constants and register-hazard helper
package cpu_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, ERROR = 2'd2} state_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  function automatic logic reg_hazard(input logic [4:0] rs, input logic uses, input logic [4:0] rd);
    return uses && (rd != 5'd0) && (rs == rd);
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between ID sources and the load in EX
import cpu_pkg::*;
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_memory_read_enable,
  input  logic [4:0] ex_reg_write_address,
  output logic       hazard
);
  assign hazard = ex_memory_read_enable &&
                  (reg_hazard(id_rs1, id_uses_rs1, ex_reg_write_address) ||
                   reg_hazard(id_rs2, id_uses_rs2, ex_reg_write_address));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer with bus handshake, watchdog and stall counter
import cpu_pkg::*;
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_memory_read_enable,
  input  logic [4:0]       ex_reg_write_address,
  input  logic             ex_jump_flag,
  input  logic             mem_memory_read_enable,
  input  logic             mem_memory_write_enable,
  input  logic             bus_ack,
  output logic             bus_req,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             bus_timeout,
  output logic [CNT_W-1:0] stall_count
);
  localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, state_next;
  logic [WD_W-1:0] wd;
  logic hazard, mem_acc, run, hold, jmp, lu, expired;
  hazard_detect u_hd (
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_memory_read_enable(ex_memory_read_enable),
    .ex_reg_write_address(ex_reg_write_address),
    .hazard(hazard)
  );
  always_comb begin
    mem_acc = mem_memory_read_enable | mem_memory_write_enable;
    run = state == RUN;
    expired = (TIMEOUT_CYCLES != 0) && (wd == WD_W'(TIMEOUT_CYCLES - 1));
    hold = rst && ((run && mem_acc) || (state == WAIT && !bus_ack) || (state == ERROR));
    jmp = rst && run && !mem_acc && ex_jump_flag;
    lu = rst && run && !mem_acc && !ex_jump_flag && hazard;
    state_next = run ? (mem_acc ? WAIT : RUN) :
                 state == WAIT ? (bus_ack ? RUN : expired ? ERROR : WAIT) : ERROR;
    pc_stall = hold | lu;
    if_id_stall = hold | lu;
    id_ex_stall = hold;
    ex_mem_stall = hold;
    mem_wb_bubble = hold;
    if_id_flush = jmp;
    id_ex_flush = jmp | lu;
  end
  assign bus_timeout = state == ERROR;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      bus_req <= 1'b0;
      wd <= '0;
      stall_count <= '0;
    end else begin
      state <= state_next;
      bus_req <= state_next == WAIT;
      wd <= state == WAIT ? wd + 1'b1 : '0;
      if (pc_stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: randomized check of pipeline_hazard_ctrl against a behavioural model
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst = 0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_ld, ex_jump, mem_rd, mem_wr, bus_ack;
  logic bus_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble;
  logic if_id_flush, id_ex_flush, bus_timeout;
  logic [CW-1:0] stall_count;
  int vectors = 0, errors = 0;
  bit m_wait, m_dead;
  int m_waited, m_cnt, dead_for, dead_limit;
  logic [10:0] exp_ctl;
  logic e_hold, e_lu, e_jmp, e_pc;
  logic [4:0] pool [4] = '{5'd0, 5'd5, 5'd7, 5'd31};

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memory_read_enable(ex_ld), .ex_reg_write_address(ex_rd),
    .ex_jump_flag(ex_jump),
    .mem_memory_read_enable(mem_rd), .mem_memory_write_enable(mem_wr),
    .bus_ack(bus_ack), .bus_req(bus_req),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .bus_timeout(bus_timeout), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] dut_ctl();
    return {bus_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble,
            if_id_flush, id_ex_flush, bus_timeout, 2'b00};
  endfunction

  task automatic model_clear();
    m_wait = 0; m_dead = 0; m_waited = 0; m_cnt = 0; dead_for = 0;
  endtask

  task automatic predict();
    bit macc, reads;
    macc = mem_rd | mem_wr;
    reads = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
    e_hold = m_dead ? 1'b1 : m_wait ? !bus_ack : macc;
    e_jmp = !m_dead && !m_wait && !macc && ex_jump;
    e_lu = !m_dead && !m_wait && !macc && !ex_jump && ex_ld && ex_rd != 0 && reads;
    e_pc = e_hold | e_lu;
    exp_ctl = {m_wait, e_pc, e_pc, e_hold, e_hold, e_hold, e_jmp, e_jmp | e_lu, m_dead, 2'b00};
  endtask

  task automatic advance();
    if (e_pc && m_cnt < CMAX) m_cnt++;
    if (m_dead) dead_for++;
    else if (m_wait) begin
      if (bus_ack) m_wait = 0;
      else if (m_waited == TO - 1) begin m_wait = 0; m_dead = 1; end
      else m_waited++;
    end else if (mem_rd | mem_wr) begin
      m_wait = 1; m_waited = 0;
    end
  endtask

  task automatic drive();
    id_rs1 = pool[$urandom_range(3)];
    id_rs2 = pool[$urandom_range(3)];
    ex_rd = pool[$urandom_range(3)];
    id_uses_rs1 = $urandom_range(1);
    id_uses_rs2 = $urandom_range(1);
    ex_ld = $urandom_range(99) < 50;
    ex_jump = $urandom_range(99) < 25;
    mem_rd = $urandom_range(99) < 12;
    mem_wr = $urandom_range(99) < 10;
    bus_ack = $urandom_range(99) < 45;
  endtask

  initial begin
    drive();
    mem_rd = 1;
    #2;
    check("reset_ctl", 32'(dut_ctl()), 32'd0);
    check("reset_cnt", 32'(stall_count), 32'd0);
    model_clear();
    dead_limit = $urandom_range(1, 90);
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst = 1;
      drive();
      #1;
      predict();
      check("ctl", 32'(dut_ctl()), 32'(exp_ctl));
      check("cnt", 32'(stall_count), 32'(m_cnt));
      if ((m_dead && dead_for >= dead_limit) || $urandom_range(99) < 2) begin
        #1 rst = 0;
        #1;
        check("rst_ctl", 32'(dut_ctl()), 32'd0);
        check("rst_cnt", 32'(stall_count), 32'd0);
        model_clear();
        dead_limit = $urandom_range(1, 90);
        @(posedge clk);
      end else begin
        @(posedge clk);
        advance();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
